// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM states and port/size constants for the RAM arbiter.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;
  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;
  localparam logic SIZE_BYTE   = 1'b0;
  localparam logic SIZE_HALF   = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; the tie goes to the port not granted last.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);
  logic last_grant;
  always_comb grant = (req[0] && req[1]) ? ~last_grant : req[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= PORT_LSU;
    else if (accept) last_grant <= grant;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: splits byte/halfword requests from two ports into single-byte RAM accesses.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [2*DATA_W-1:0] m0_wdata,
  input  logic                m0_we,
  input  logic                m0_wide,
  output logic                m0_rsp_valid,
  output logic [2*DATA_W-1:0] m0_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [2*DATA_W-1:0] m1_wdata,
  input  logic                m1_we,
  input  logic                m1_wide,
  output logic                m1_rsp_valid,
  output logic [2*DATA_W-1:0] m1_rdata,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_r_w,
  input  logic [DATA_W-1:0]   ram_rdata
);
  state_t state, state_nxt;
  logic grant, accept, idle, rd_done;
  logic req_port, req_we, req_wide;
  logic [ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata, resp_data, rd0, rd1;
  logic [DATA_W-1:0] lo_byte;

  rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({m1_req_valid, m0_req_valid}),
    .accept(accept),
    .grant(grant)
  );

  always_comb begin
    idle = state == IDLE;
    accept = idle && (m0_req_valid || m1_req_valid);
    m0_req_ready = idle && m0_req_valid && grant == PORT_IFETCH;
    m1_req_ready = idle && m1_req_valid && grant == PORT_LSU;
    ram_en = state == BYTE0 || state == BYTE1;
    ram_addr = req_addr + ADDR_W'(state == BYTE1);
    ram_wdata = state == BYTE1 ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    ram_r_w = req_we;
    m0_rsp_valid = state == RESP && req_port == PORT_IFETCH;
    m1_rsp_valid = state == RESP && req_port == PORT_LSU;
    rd_done = state == RESP && !req_we;
    // the final byte comes straight from the RAM so rdata is valid in the pulse cycle
    resp_data = req_wide == SIZE_HALF ? {ram_rdata, lo_byte} : {{DATA_W{1'b0}}, ram_rdata};
    m0_rdata = (rd_done && req_port == PORT_IFETCH) ? resp_data : rd0;
    m1_rdata = (rd_done && req_port == PORT_LSU) ? resp_data : rd1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = accept ? BYTE0 : IDLE;
      BYTE0: state_nxt = req_wide == SIZE_HALF ? BYTE1 : RESP;
      BYTE1: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req_port <= PORT_IFETCH;
      req_addr <= '0;
      req_wdata <= '0;
      req_we <= 1'b0;
      req_wide <= SIZE_BYTE;
      lo_byte <= '0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_port <= grant;
        req_addr <= grant ? m1_addr : m0_addr;
        req_wdata <= grant ? m1_wdata : m0_wdata;
        req_we <= grant ? m1_we : m0_we;
        req_wide <= grant ? m1_wide : m0_wide;
      end
      if (state == BYTE1) lo_byte <= ram_rdata;
      if (rd_done && req_port == PORT_IFETCH) rd0 <= resp_data;
      if (rd_done && req_port == PORT_LSU) rd1 <= resp_data;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v [2], rdy [2], we [2], wide [2], rv [2];
  logic [7:0] a [2];
  logic [15:0] wd [2], rd [2];
  logic ram_en, ram_r_w;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0] mem [256], ref_mem [256];
  int tests = 0, fails = 0, cyc = 0;
  int dacc [2], drsp [2];
  int dgr [$];
  bit busy, last = 1'b1, w, tp, twe, twide;
  int k, len, lat;
  logic [7:0] ta, ea;
  logic [15:0] twd, d;
  logic [15:0] exp_rd [2];

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(v[0]), .m0_req_ready(rdy[0]), .m0_addr(a[0]), .m0_wdata(wd[0]),
    .m0_we(we[0]), .m0_wide(wide[0]), .m0_rsp_valid(rv[0]), .m0_rdata(rd[0]),
    .m1_req_valid(v[1]), .m1_req_ready(rdy[1]), .m1_addr(a[1]), .m1_wdata(wd[1]),
    .m1_we(we[1]), .m1_wide(wide[1]), .m1_rsp_valid(rv[1]), .m1_rdata(rd[1]),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_r_w(ram_r_w),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_r_w) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // reference model: each accepted transaction occupies 1 or 2 access cycles, then one response cycle
  always @(negedge clk) begin
    if (rst) begin
      busy = 0; last = 1; exp_rd[0] = 0; exp_rd[1] = 0;
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_r_w", ram_r_w, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_ready0", rdy[0], 0);
      chk("rst_ready1", rdy[1], 0);
      chk("rst_rsp0", rv[0], 0);
      chk("rst_rsp1", rv[1], 0);
      chk("rst_rdata0", rd[0], 0);
      chk("rst_rdata1", rd[1], 0);
    end else if (!busy) begin
      chk("idle_ram_en", ram_en, 0);
      chk("idle_rsp0", rv[0], 0);
      chk("idle_rsp1", rv[1], 0);
      chk("idle_rdata0", rd[0], exp_rd[0]);
      chk("idle_rdata1", rd[1], exp_rd[1]);
      if (v[0] && v[1]) w = !last;
      else w = v[1];
      chk("ready0", rdy[0], v[0] && w == 0);
      chk("ready1", rdy[1], v[1] && w == 1);
      if (v[0] || v[1]) begin
        tp = w; ta = a[w]; twd = wd[w]; twe = we[w]; twide = wide[w];
        last = w; busy = 1; k = 0;
        if (twe) begin
          ref_mem[ta] = twd[7:0];
          if (twide) ref_mem[ta + 8'd1] = twd[15:8];
        end
      end
    end else begin
      k++;
      len = twide ? 3 : 2;
      chk("busy_ready0", rdy[0], 0);
      chk("busy_ready1", rdy[1], 0);
      if (k < len) begin
        ea = ta + 8'(k - 1);
        chk("acc_ram_en", ram_en, 1);
        chk("acc_ram_addr", ram_addr, ea);
        chk("acc_ram_r_w", ram_r_w, twe);
        if (twe) chk("acc_ram_wdata", ram_wdata, k == 1 ? twd[7:0] : twd[15:8]);
        chk("acc_rsp0", rv[0], 0);
        chk("acc_rsp1", rv[1], 0);
      end else begin
        if (!twe) exp_rd[tp] = twide ? {ref_mem[ta + 8'd1], ref_mem[ta]} : {8'h00, ref_mem[ta]};
        chk("resp_ram_en", ram_en, 0);
        chk("resp_valid", rv[tp], 1);
        chk("resp_other", rv[!tp], 0);
        busy = 0;
      end
      chk("busy_rdata0", rd[0], exp_rd[0]);
      chk("busy_rdata1", rd[1], exp_rd[1]);
    end
  end

  always @(negedge clk)
    if (!rst)
      for (int p = 0; p < 2; p++) begin
        if (v[p] && rdy[p]) begin dacc[p] = cyc; dgr.push_back(p); end
        if (rv[p]) drsp[p] = cyc;
      end

  task automatic issue(input int p, input logic [7:0] ad, input logic [15:0] dd,
                       input logic wr, input logic h);
    v[p] = 1; a[p] = ad; wd[p] = dd; we[p] = wr; wide[p] = h;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[p]) begin
        @(posedge clk); #1;
        v[p] = 0;
        return;
      end
    end
    chk("accept_timeout", rdy[p], 1);
    v[p] = 0;
  endtask

  task automatic wait_rsp(input int p, output int l, output logic [15:0] dq);
    l = -1; dq = 16'hxxxx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rv[p]) begin
        l = i; dq = rd[p];
        @(posedge clk); #1;
        return;
      end
    end
    chk("rsp_timeout", rv[p], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    for (int p = 0; p < 2; p++) begin
      v[p] = 0; a[p] = 0; wd[p] = 0; we[p] = 0; wide[p] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    issue(0, 8'h10, 16'h00A5, 1, 0);
    wait_rsp(0, lat, d);
    chk("byte_wr_latency", lat, 2);
    issue(0, 8'h10, 16'h0000, 0, 0);
    wait_rsp(0, lat, d);
    chk("byte_rd_latency", lat, 2);
    chk("byte_rd_data", d, 16'h00A5);
    issue(1, 8'hFF, 16'hBEEF, 1, 1);
    wait_rsp(1, lat, d);
    chk("half_wr_latency", lat, 3);
    chk("wrap_lo_byte", mem[8'hFF], 8'hEF);
    chk("wrap_hi_byte", mem[8'h00], 8'hBE);
    issue(1, 8'hFF, 16'h0000, 0, 1);
    wait_rsp(1, lat, d);
    chk("half_rd_latency", lat, 3);
    chk("half_rd_data", d, 16'hBEEF);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    dgr.delete();
    fork
      begin issue(0, 8'h20, 16'h0, 0, 0); issue(0, 8'h21, 16'h0, 0, 1); end
      begin issue(1, 8'h30, 16'h0, 0, 0); issue(1, 8'h31, 16'h0, 0, 0); end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("rr_count", dgr.size(), 4);
    if (dgr.size() == 4) begin
      chk("rr_grant0", dgr[0], 0);
      chk("rr_grant1", dgr[1], 1);
      chk("rr_grant2", dgr[2], 0);
      chk("rr_grant3", dgr[3], 1);
    end
    issue(0, 8'h40, 16'h0, 0, 1);
    @(posedge clk); #1;
    issue(1, 8'h50, 16'h0, 0, 0);
    chk("busy_wait_accept", dacc[1], drsp[0] + 1);
    wait_rsp(1, lat, d);
    chk("late_rd_data", d, {8'h00, ref_mem[8'h50]});
    issue(1, 8'h60, 16'h0, 0, 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_no_rsp", rv[1], 0);
    @(posedge clk); #1;
    rst = 0;
    issue(1, 8'h60, 16'h0, 0, 0);
    wait_rsp(1, lat, d);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_data", d, 16'h00A3);
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
